// File: rtl/pol_ser_pp_if.sv
// Handshake bundle for pol_ser_pp: parallel-lane input beats in, one coefficient per cycle out.
interface pol_ser_pp_if #(
    parameter int W     = 16,
    parameter int LANES = 16,
    parameter int N     = 256
);
    localparam int AW = $clog2(N);

    logic               in_valid;
    logic               in_ready;
    logic [LANES*W-1:0] in_data;
    logic               order;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic [AW-1:0]      out_idx;
    logic               out_last;
    logic               poly_done;

    modport master (
        output in_valid, in_data, order, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, poly_done
    );

    modport slave (
        input  in_valid, in_data, order, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, poly_done
    );
endinterface

// File: rtl/pol_ser_pp.sv
// Ping-pong polynomial serializer: captures LANES coefficients per beat into one of two banks
// and streams a full bank out one coefficient per cycle in natural or bit-reversed order.
module pol_ser_pp #(
    parameter int W     = 16,
    parameter int LANES = 16,
    parameter int N     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    pol_ser_pp_if.slave bus
);
    localparam int BEATS = N / LANES;
    localparam int AW    = $clog2(N);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = $clog2(LANES);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t bank_state     [2];
    bank_state_t bank_state_nxt [2];

    logic          wr_bank, wr_bank_nxt;
    logic [BW-1:0] wr_beat, wr_beat_nxt;
    logic          rd_bank, rd_bank_nxt;
    logic [AW-1:0] rd_cnt, rd_cnt_nxt;
    logic          rd_order, rd_order_nxt;

    logic          out_valid_q, out_valid_nxt;
    logic [W-1:0]  out_data_q, out_data_nxt;
    logic [AW-1:0] out_idx_q, out_idx_nxt;
    logic          out_last_q, out_last_nxt;
    logic          poly_done_q, poly_done_nxt;

    logic                     in_accept;
    logic                     rd_start;
    logic                     rd_load;
    logic [AW-1:0]            rd_addr;
    logic [LW-1:0]            rd_lane;
    logic [BW-1:0]            rd_beat;
    logic [LANES-1:0][W-1:0]  lane_rd;
    logic [W-1:0]             rd_word;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = x[AW-1-i];
        return r;
    endfunction

    assign bus.in_ready = (bank_state[wr_bank] == EMPTY) || (bank_state[wr_bank] == FILLING);
    assign in_accept    = bus.in_valid && bus.in_ready && !flush;

    // On the first load rd_cnt is 0, so the stale rd_order cannot change the address.
    assign rd_start = (bank_state[rd_bank] == FULL);
    assign rd_load  = (!out_valid_q || bus.out_ready) &&
                      (rd_start || (bank_state[rd_bank] == DRAINING));
    assign rd_addr  = rd_order ? bitrev(rd_cnt) : rd_cnt;
    assign rd_lane  = LW'(rd_addr >> $clog2(BEATS));
    assign rd_beat  = BW'(rd_addr & AW'(BEATS - 1));
    assign rd_word  = lane_rd[rd_lane];

    // Each lane owns its own slice of both banks; lane l beat b is natural index l*BEATS + b.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [W-1:0] lane_mem [2][BEATS];

        always_ff @(posedge clk) begin
            if (in_accept) lane_mem[wr_bank][wr_beat] <= bus.in_data[l*W +: W];
        end

        assign lane_rd[l] = lane_mem[rd_bank][rd_beat];
    end

    always_comb begin
        bank_state_nxt = bank_state;
        wr_bank_nxt    = wr_bank;
        wr_beat_nxt    = wr_beat;
        rd_bank_nxt    = rd_bank;
        rd_cnt_nxt     = rd_cnt;
        rd_order_nxt   = rd_order;
        out_valid_nxt  = out_valid_q;
        out_data_nxt   = out_data_q;
        out_idx_nxt    = out_idx_q;
        out_last_nxt   = out_last_q;
        poly_done_nxt  = out_valid_q && bus.out_ready && out_last_q;

        if (flush) begin
            bank_state_nxt[0] = EMPTY;
            bank_state_nxt[1] = EMPTY;
            wr_bank_nxt       = 1'b0;
            wr_beat_nxt       = '0;
            rd_bank_nxt       = 1'b0;
            rd_cnt_nxt        = '0;
            out_valid_nxt     = 1'b0;
            poly_done_nxt     = 1'b0;
        end else begin
            if (in_accept) begin
                if (wr_beat == BW'(BEATS - 1)) begin
                    bank_state_nxt[wr_bank] = FULL;
                    wr_beat_nxt             = '0;
                    wr_bank_nxt             = !wr_bank;
                end else begin
                    bank_state_nxt[wr_bank] = FILLING;
                    wr_beat_nxt             = wr_beat + 1'b1;
                end
            end

            // Writer and reader never own the same bank, so both updates can land together.
            if (rd_load) begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = rd_word;
                out_idx_nxt   = rd_addr;
                out_last_nxt  = (rd_cnt == AW'(N - 1));
                rd_cnt_nxt    = rd_cnt + 1'b1;
                if (rd_start) begin
                    rd_order_nxt            = bus.order;
                    bank_state_nxt[rd_bank] = DRAINING;
                end
                if (rd_cnt == AW'(N - 1)) begin
                    bank_state_nxt[rd_bank] = EMPTY;
                    rd_bank_nxt             = !rd_bank;
                end
            end else if (bus.out_ready) begin
                out_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_state  <= '{EMPTY, EMPTY};
            wr_bank     <= 1'b0;
            wr_beat     <= '0;
            rd_bank     <= 1'b0;
            rd_cnt      <= '0;
            rd_order    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            poly_done_q <= 1'b0;
        end else begin
            bank_state  <= bank_state_nxt;
            wr_bank     <= wr_bank_nxt;
            wr_beat     <= wr_beat_nxt;
            rd_bank     <= rd_bank_nxt;
            rd_cnt      <= rd_cnt_nxt;
            rd_order    <= rd_order_nxt;
            out_valid_q <= out_valid_nxt;
            out_data_q  <= out_data_nxt;
            out_idx_q   <= out_idx_nxt;
            out_last_q  <= out_last_nxt;
            poly_done_q <= poly_done_nxt;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.poly_done = poly_done_q;
endmodule

// File: tb/tb_pol_ser_pp.sv
// Directed bench for pol_ser_pp: default instance against a coefficient scoreboard,
// plus a small W=12/LANES=4/N=64 instance for the parameter sweep.
module tb_pol_ser_pp;
    localparam int W      = 16;
    localparam int LANES  = 16;
    localparam int N      = 256;
    localparam int BEATS  = N / LANES;
    localparam int W2     = 12;
    localparam int LANES2 = 4;
    localparam int N2     = 64;
    localparam int BEATS2 = N2 / LANES2;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   vec_count = 0;
    int   err_count = 0;
    int   rx_count  = 0;
    logic last_hs   = 1'b0;
    exp_t exp_q[$];

    pol_ser_pp_if #(.W(W),  .LANES(LANES),  .N(N))  bus  ();
    pol_ser_pp_if #(.W(W2), .LANES(LANES2), .N(N2)) bus2 ();

    pol_ser_pp #(.W(W), .LANES(LANES), .N(N)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus)
    );

    pol_ser_pp #(.W(W2), .LANES(LANES2), .N(N2)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bitrev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Presents nbeats beats of polynomial `base`; a complete polynomial is also queued as expected output.
    task automatic applyStimulus(input logic [15:0] base, input logic ord, input bit gaps, input int nbeats);
        bit   accepted;
        int   tries;
        exp_t e;
        bus.order = ord;
        if (nbeats == BEATS) begin
            for (int k = 0; k < N; k++) begin
                e.idx  = ord ? bitrev8(8'(k)) : 8'(k);
                e.data = base + 16'(e.idx);
                e.last = (k == N - 1);
                exp_q.push_back(e);
            end
        end
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < LANES; l++) bus.in_data[l*W +: W] = base + 16'(16*l + b);
            accepted = 1'b0;
            tries    = 0;
            while (!accepted && tries < 2000) begin
                bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                accepted     = bus.in_valid && bus.in_ready;
                stepCycle();
                tries++;
            end
            bus.in_valid = 1'b0;
            if (!accepted) begin
                checkOutput("in_timeout", 32'(0), 32'(1));
                return;
            end
        end
    endtask

    task automatic waitDrain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            stepCycle();
            t++;
        end
        checkOutput("drain_left", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic waitRx(input int target);
        int t = 0;
        while (rx_count < target && t < 2000) begin
            stepCycle();
            t++;
        end
        checkOutput("rx_reach", 32'(rx_count >= target), 32'(1));
    endtask

    // Scoreboard: every valid coefficient must match the queue head, stalled or not.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_hs = 1'b0;
        end else begin
            checkOutput("poly_done", 32'(bus.poly_done), 32'(last_hs));
            last_hs = 1'b0;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_valid", 32'(bus.out_valid), 32'(0));
                end else begin
                    e = exp_q[0];
                    checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
                    checkOutput("out_idx",  32'(bus.out_idx),  32'(e.idx));
                    checkOutput("out_last", 32'(bus.out_last), 32'(e.last));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        rx_count++;
                        last_hs = e.last;
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] bitrev_first [4];
        int         t;
        int         k;
        int         gapless;
        bit         send_done;

        bitrev_first = '{8'd0, 8'd128, 8'd64, 8'd192};
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0; bus.in_data  = '0; bus.order  = 1'b0; bus.out_ready  = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.order = 1'b0; bus2.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'(1));
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("rst_out_data",  32'(bus.out_data),  32'(0));
        checkOutput("rst_out_idx",   32'(bus.out_idx),   32'(0));
        checkOutput("rst_out_last",  32'(bus.out_last),  32'(0));
        checkOutput("rst_poly_done", 32'(bus.poly_done), 32'(0));
        #2 reset = 1'b0;
        stepCycle();

        // Natural order with latency check
        bus.out_ready = 1'b1;
        applyStimulus(16'h1000, 1'b0, 1'b0, BEATS);
        checkOutput("lat_t1_valid", 32'(bus.out_valid), 32'(0));
        stepCycle();
        checkOutput("lat_t2_valid", 32'(bus.out_valid), 32'(1));
        waitDrain(1000);
        stepCycle();

        // Bit-reversed order, stepping the first four coefficients by hand
        bus.out_ready = 1'b0;
        applyStimulus(16'h1000, 1'b1, 1'b0, BEATS);
        t = 0;
        while (!bus.out_valid && t < 20) begin stepCycle(); t++; end
        for (int j = 0; j < 4; j++) begin
            checkOutput("brv_idx",  32'(bus.out_idx),  32'(bitrev_first[j]));
            checkOutput("brv_data", 32'(bus.out_data), 32'(16'h1000 + 16'(bitrev_first[j])));
            bus.out_ready = 1'b1;
            stepCycle();
            bus.out_ready = 1'b0;
        end
        bus.out_ready = 1'b1;
        waitDrain(1000);
        stepCycle();

        // Ping-pong: two full banks block the writer until the first drains
        bus.out_ready = 1'b0;
        applyStimulus(16'h2000, 1'b0, 1'b0, BEATS);
        checkOutput("pp_ready_after16", 32'(bus.in_ready), 32'(1));
        applyStimulus(16'h3000, 1'b0, 1'b0, BEATS);
        checkOutput("pp_ready_after32", 32'(bus.in_ready), 32'(0));
        checkOutput("pp_valid_stalled", 32'(bus.out_valid), 32'(1));
        fork
            begin
                bus.out_ready = 1'b1;
                gapless = 0;
                for (int i = 0; i < 2*N; i++) begin
                    if (bus.out_valid) gapless++;
                    stepCycle();
                end
                checkOutput("pp_gapless", 32'(gapless), 32'(2*N));
            end
            begin
                applyStimulus(16'h4000, 1'b0, 1'b0, BEATS);
            end
        join
        waitDrain(1000);
        stepCycle();

        // Random back-pressure and input gaps over four polynomials
        send_done = 1'b0;
        fork
            begin
                applyStimulus(16'h5000, 1'b1, 1'b1, BEATS);
                applyStimulus(16'h6000, 1'b1, 1'b1, BEATS);
                applyStimulus(16'h7000, 1'b1, 1'b1, BEATS);
                applyStimulus(16'h8000, 1'b1, 1'b1, BEATS);
                send_done = 1'b1;
            end
            begin
                t = 0;
                while (!(send_done && exp_q.size() == 0) && t < 20000) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    stepCycle();
                    t++;
                end
                bus.out_ready = 1'b1;
            end
        join
        checkOutput("rnd_drained", 32'(exp_q.size()), 32'(0));
        stepCycle();

        // Flush during a fill; a beat offered in the flush cycle is dropped
        applyStimulus(16'h9000, 1'b0, 1'b0, 8);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = {LANES{16'hDEAD}};
        stepCycle();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flf_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("flf_in_ready",  32'(bus.in_ready),  32'(1));
        applyStimulus(16'hA000, 1'b0, 1'b0, BEATS);
        waitDrain(1000);
        stepCycle();

        // Flush while draining at k = 100
        rx_count = 0;
        applyStimulus(16'hB000, 1'b0, 1'b0, BEATS);
        waitRx(100);
        bus.out_ready = 1'b0;
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        exp_q.delete();
        checkOutput("fld_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("fld_in_ready",  32'(bus.in_ready),  32'(1));
        bus.out_ready = 1'b1;
        applyStimulus(16'hC000, 1'b0, 1'b0, BEATS);
        waitDrain(1000);
        stepCycle();

        // Asynchronous reset mid-drain
        rx_count = 0;
        applyStimulus(16'hD000, 1'b1, 1'b0, BEATS);
        waitRx(50);
        bus.out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("ar_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("ar_in_ready",  32'(bus.in_ready),  32'(1));
        checkOutput("ar_out_idx",   32'(bus.out_idx),   32'(0));
        exp_q.delete();
        @(posedge clk);
        #3 reset = 1'b0;
        stepCycle();
        bus.out_ready = 1'b1;
        applyStimulus(16'hE000, 1'b0, 1'b0, BEATS);
        waitDrain(1000);
        stepCycle();

        // Parameter sweep: W=12, LANES=4, N=64
        bus2.out_ready = 1'b1;
        for (int b = 0; b < BEATS2; b++) begin
            if (b == BEATS2 - 1) begin
                stepCycle();
                stepCycle();
                checkOutput("sw_partial_valid", 32'(bus2.out_valid), 32'(0));
            end
            for (int l = 0; l < LANES2; l++) bus2.in_data[l*W2 +: W2] = 12'h100 + 12'(16*l + b);
            bus2.in_valid = 1'b1;
            t = 0;
            while (!bus2.in_ready && t < 100) begin stepCycle(); t++; end
            stepCycle();
            bus2.in_valid = 1'b0;
        end
        checkOutput("sw_lat_t1", 32'(bus2.out_valid), 32'(0));
        stepCycle();
        checkOutput("sw_lat_t2", 32'(bus2.out_valid), 32'(1));
        k = 0;
        t = 0;
        while (k < N2 && t < 500) begin
            if (bus2.out_valid) begin
                checkOutput("sw_data", 32'(bus2.out_data), 32'(12'h100 + 12'(k)));
                checkOutput("sw_idx",  32'(bus2.out_idx),  32'(k));
                checkOutput("sw_last", 32'(bus2.out_last), 32'(k == N2 - 1));
                k++;
            end
            stepCycle();
            t++;
        end
        checkOutput("sw_count",     32'(k),                32'(N2));
        checkOutput("sw_poly_done", 32'(bus2.poly_done),   32'(1));
        checkOutput("sw_idle",      32'(bus2.out_valid),   32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule

// File: doc/pol_ser_pp.md
# pol_ser_pp

Parametrised ping-pong polynomial serializer for the Kyber datapath. It accepts a polynomial as `LANES` parallel coefficient lanes over `N/LANES` beats, for example from the INTT butterfly array. It buffers the polynomial in one of two banks and streams it out one coefficient per cycle over a valid/ready interface, in natural or bit-reversed index order. Double buffering lets the next polynomial be captured while the previous one drains.

## Interface
- `W`, 16: coefficient width in bits.
- `LANES`, 16: parallel input lanes; power of two, ≥2.
- `N`, 256: coefficients per polynomial; power of two, multiple of `LANES`. Derived: `BEATS = N/LANES`, `AW = log2(N)`.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous clear of both banks and both pointers; takes priority over all other inputs.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `in_data` in `LANES*W`: lane `l` occupies bits `[l*W +: W]`.
- `order` in 1: 0 = natural output order, 1 = bit-reversed order. Sampled when a bank starts draining.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: output coefficient consumed when `out_valid && out_ready`.
- `out_data` out `W`: coefficient.
- `out_idx` out `AW`: natural index of the coefficient on `out_data`.
- `out_last` out 1: high with the final coefficient of a polynomial.
- `poly_done` out 1: one-cycle pulse on the cycle after the `out_last` handshake.

## Operation
- Storage: two banks of `N`×`W` registers (bank 0 and bank 1). Bank contents are not reset.
- Input mapping: on accepted beat `b` (0..BEATS-1), lane `l` is written to index `l*BEATS + b` of the write bank.
- Bank state: each bank has a 2-bit state, EMPTY → FILLING → FULL → DRAINING → EMPTY.
- Write side: registers `wr_bank` and `wr_beat`. `in_ready = (state[wr_bank] == EMPTY || state[wr_bank] == FILLING)`.
  - The first accepted beat sets the bank to FILLING.
  - The beat with `wr_beat == BEATS-1` sets it FULL, clears `wr_beat`, and toggles `wr_bank`.
- Read side: registers `rd_bank`, `rd_cnt` (`AW` bits) and `rd_order`.
  - When `state[rd_bank] == FULL` and the output stage can load, the bank goes to DRAINING, `order` is latched into `rd_order`, and `rd_cnt = 0`.
  - Read address = `rd_cnt` if `rd_order == 0`, otherwise `bitrev_AW(rd_cnt)`.
- Output stage: one register holding `out_data`, `out_idx` and `out_last`.
  - It loads when `(!out_valid || out_ready)` and the read bank is FULL or DRAINING with coefficients remaining.
  - `out_last` is set when `rd_cnt == N-1`.
  - On that load the bank goes to EMPTY, `rd_bank` toggles, and `rd_cnt` wraps to 0.
- Simultaneous events:
  - Writer and reader on different banks proceed independently.
  - A bank freed by the reader is writable from the next cycle (state is registered).
  - A bank that becomes FULL is readable from the next cycle.
- Flush: both banks go EMPTY; `wr_bank`, `rd_bank`, `wr_beat` and `rd_cnt` go to 0; `out_valid` is cleared. A beat presented in the flush cycle is dropped.
- Reset mid-operation: all state clears asynchronously. Any partial polynomial is discarded.

## Timing
- Reset values:
  - `in_ready` = 1 (bank 0 EMPTY).
  - `out_valid` = 0, `out_data` = 0, `out_idx` = 0, `out_last` = 0, `poly_done` = 0.
  - Both banks EMPTY; `wr_bank`, `rd_bank`, `wr_beat` and `rd_cnt` all 0.
- Fill latency: a polynomial takes `BEATS` accepted beats (16 with defaults). Gaps in `in_valid` stall `wr_beat`.
- Output latency: last input beat accepted in cycle t → first `out_valid` in cycle t+2, provided the read side is idle.
- Throughput: with `out_ready` held high, one coefficient per cycle; `N` cycles per polynomial, with no bubble between back-to-back full banks.
- Output stability: `out_data`, `out_idx` and `out_last` hold while `out_valid && !out_ready`.
- Back-pressure: with both banks FULL or DRAINING, `in_ready` = 0 until the draining bank's last coefficient loads into the output stage.

## Test plan
- Natural order:
  - Stimulus: reset, then 16 beats with lane `l`, beat `b` carrying `16'h1000 + 16*l + b`; `order` = 0; `out_ready` held 1.
  - Required: 256 outputs with `out_data = 16'h1000 + k` and `out_idx = k`; `out_last` only at k = 255; `poly_done` one cycle later; first `out_valid` 2 cycles after the last beat.
- Bit-reversed order:
  - Stimulus: same data with `order` = 1.
  - Required: the output sequence starts at indices 0, 128, 64, 192; each `out_data = 16'h1000 + out_idx`.
- Ping-pong:
  - Stimulus: three polynomials sent back-to-back with `out_ready` = 0.
  - Required: `in_ready` drops after the 32nd beat. Releasing `out_ready` drains polynomial 1 (256 cycles, no gaps), then polynomial 2 immediately; polynomial 3 is then accepted.
- Random back-pressure:
  - Stimulus: 50% random `out_ready` and 50% random `in_valid` gaps over 4 polynomials.
  - Required: no coefficient lost, duplicated or reordered against the scoreboard; outputs stable while stalled.
- Flush and reset:
  - Stimulus: `flush` asserted after beat 7 of a fill, and separately while draining at k = 100; then an asynchronous `reset` pulse mid-drain.
  - Required: `out_valid` = 0 the next cycle and `in_ready` = 1. A fresh polynomial afterwards streams correctly from index 0.
- Parameter sweep:
  - Stimulus: `W`=12, `LANES`=4, `N`=64.
  - Required: 16 beats per polynomial, 64 outputs, correct mapping `l*16 + b`.
